// File: rtl/alu.sv
// 32-bit MIPS-style ALU: R-type add/sub/logic/slt/shifts with registered result and flags.
// Optional ALU_OVERFLOW_EN adds registered signed-overflow detection for ADD/SUB.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  sa,
    input  logic [5:0]  op,
    output logic [31:0] r,
    output logic        zero,
    output logic        negative,
    output logic        positive,
    output logic        out_valid,
    output logic        overflow
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLLV = 6'b000100;
    localparam logic [5:0] OP_SRLV = 6'b000110;
    localparam logic [5:0] OP_SRAV = 6'b000111;

    logic [DW-1:0] r_q, r_d;
    logic          zero_q, zero_d;
    logic          negative_q, negative_d;
    logic          positive_q, positive_d;
    logic          out_valid_q, out_valid_d;

    logic [DW-1:0] res_c;
    logic [SW-1:0] fix_sh_c;
    logic [SW-1:0] var_sh_c;

    // Upper bit of the fixed shift field is architecturally ignored.
    logic unused_sa_msb;
    assign unused_sa_msb = sa[5];

    assign fix_sh_c = sa[SW-1:0];
    assign var_sh_c = b[SW-1:0];

    // Function-code decode and datapath.
    always_comb begin
        res_c = '0;
        unique case (op)
            OP_ADD:  res_c = a + b;
            OP_SUB:  res_c = a - b;
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_SLT:  res_c = DW'(($signed(a) < $signed(b)) ? 1'b1 : 1'b0);
            OP_SLL:  res_c = a << fix_sh_c;
            OP_SRL:  res_c = a >> fix_sh_c;
            OP_SRA:  res_c = DW'($signed(a) >>> fix_sh_c);
            OP_SLLV: res_c = a << var_sh_c;
            OP_SRLV: res_c = a >> var_sh_c;
            OP_SRAV: res_c = DW'($signed(a) >>> var_sh_c);
            default: res_c = '0;
        endcase
    end

    // Result/flag next-state: hold when no valid input.
    always_comb begin
        r_d         = r_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        positive_d  = positive_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            r_d        = res_c;
            zero_d     = (res_c == '0);
            negative_d = res_c[DW-1];
            positive_d = (res_c != '0) && !res_c[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q         <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            positive_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            positive_q  <= positive_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic overflow_q, overflow_d;
    logic ovf_c;

    // Signed overflow: compare result sign against operand signs.
    always_comb begin
        ovf_c = 1'b0;
        if (op == OP_ADD) begin
            ovf_c = (a[DW-1] == b[DW-1]) && (res_c[DW-1] != a[DW-1]);
        end else if (op == OP_SUB) begin
            ovf_c = (a[DW-1] != b[DW-1]) && (res_c[DW-1] != a[DW-1]);
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (in_valid) begin
            overflow_d = ovf_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign r         = r_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign positive  = positive_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan vectors plus randomized stream vs. an arithmetic model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sa;
    logic [5:0]  op;
    logic [31:0] r;
    logic        zero;
    logic        negative;
    logic        positive;
    logic        out_valid;
    logic        overflow;

    int n_cmp;
    int n_err;

    alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .sa       (sa),
        .op       (op),
        .r        (r),
        .zero     (zero),
        .negative (negative),
        .positive (positive),
        .out_valid(out_valid),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  sa;
        logic [31:0] r;
    } vec_t;

    // Two's-complement value of a 32-bit word as a 64-bit integer.
    function automatic longint sval(input logic [31:0] x);
        longint v;
        v = longint'({32'b0, x});
        if (x[31]) v = v - 64'sd4294967296;
        return v;
    endfunction

    // Reference result built from arithmetic and single-bit shift steps.
    function automatic logic [31:0] model_r(input logic [5:0] o, input logic [31:0] xa,
                                            input logic [31:0] xb, input logic [5:0] xs);
        logic [31:0] x;
        int amt;
        x = xa;
        amt = 0;
        case (o)
            6'b000000, 6'b000010, 6'b000011: amt = int'(xs % 6'd32);
            6'b000100, 6'b000110, 6'b000111: amt = int'(xb % 32'd32);
            default: amt = 0;
        endcase
        case (o)
            6'b100000: return xa + xb;
            6'b100010: return xa - xb;
            6'b100100: return xa & xb;
            6'b100101: return xa | xb;
            6'b100110: return xa ^ xb;
            6'b101010: return (sval(xa) < sval(xb)) ? 32'd1 : 32'd0;
            6'b000000, 6'b000100: begin
                for (int i = 0; i < amt; i++) x = x * 32'd2;
                return x;
            end
            6'b000010, 6'b000110: begin
                for (int i = 0; i < amt; i++) x = x / 32'd2;
                return x;
            end
            6'b000011, 6'b000111: begin
                for (int i = 0; i < amt; i++) x = {x[31], x[31:1]};
                return x;
            end
            default: return 32'd0;
        endcase
    endfunction

    // Overflow = true signed result leaves the 32-bit signed range.
    function automatic logic model_ovf(input logic [5:0] o, input logic [31:0] xa, input logic [31:0] xb);
`ifdef ALU_OVERFLOW_EN
        longint s;
        if (o == 6'b100000) s = sval(xa) + sval(xb);
        else if (o == 6'b100010) s = sval(xa) - sval(xb);
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [5:0] xs);
        in_valid = v;
        op = o;
        a = xa;
        b = xb;
        sa = xs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 6'b100000, 32'h1234_5678, 32'h1, 6'd0);
        n_cmp++;
        if (r !== 32'd0) begin n_err++; $display("FAIL reset_r: got %h want 0", r); end
        n_cmp++;
        if ({zero, negative, positive} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b want 000", {zero, negative, positive});
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rst_n = 1'b1;
        drive(1'b0, 6'b100000, 32'hFFFF_FFFF, 32'h1, 6'd3);
        n_cmp++;
        if ({r, zero, negative, positive, out_valid} !== {32'd0, 4'b0000}) begin
            n_err++; $display("FAIL reset_hold: got r=%h z/n/p/v=%b want r=0 0000",
                              r, {zero, negative, positive, out_valid});
        end
    endtask

    task automatic test_directed;
        vec_t v[$];
        logic [31:0] er;
        v.push_back('{6'b100000, 32'h8, 32'hF, 6'd1, 32'h17});
        v.push_back('{6'b100010, 32'h8, 32'hF, 6'd1, 32'hFFFF_FFF9});
        v.push_back('{6'b101010, 32'h8, 32'hF, 6'd1, 32'h1});
        v.push_back('{6'b100100, 32'h8, 32'hF, 6'd1, 32'h8});
        v.push_back('{6'b100101, 32'h8, 32'hF, 6'd1, 32'hF});
        v.push_back('{6'b100110, 32'h8, 32'hF, 6'd1, 32'h7});
        v.push_back('{6'b000000, 32'h8, 32'hF, 6'd1, 32'h10});
        v.push_back('{6'b000100, 32'h8, 32'hF, 6'd1, 32'h4_0000});
        v.push_back('{6'b000010, 32'h8, 32'hF, 6'd1, 32'h4});
        v.push_back('{6'b000110, 32'h8, 32'hF, 6'd1, 32'h0});
        v.push_back('{6'b100000, 32'h0, 32'h1, 6'd15, 32'h1});
        v.push_back('{6'b100010, 32'h0, 32'h1, 6'd15, 32'hFFFF_FFFF});
        v.push_back('{6'b101010, 32'h0, 32'h1, 6'd15, 32'h1});
        v.push_back('{6'b000000, 32'h0, 32'h1, 6'd15, 32'h0});
        v.push_back('{6'b000010, 32'h0, 32'h1, 6'd15, 32'h0});
        v.push_back('{6'b000011, 32'h0, 32'h1, 6'd15, 32'h0});
        v.push_back('{6'b000100, 32'h0, 32'h1, 6'd15, 32'h0});
        v.push_back('{6'b000110, 32'h0, 32'h1, 6'd15, 32'h0});
        v.push_back('{6'b000111, 32'h0, 32'h1, 6'd15, 32'h0});
        v.push_back('{6'b100000, 32'h0000_FFFF, 32'h1, 6'd15, 32'h0001_0000});
        v.push_back('{6'b100010, 32'h0000_FFFF, 32'h1, 6'd15, 32'h0000_FFFE});
        v.push_back('{6'b101010, 32'h0000_FFFF, 32'h1, 6'd15, 32'h0});
        v.push_back('{6'b000011, 32'h0000_FFFF, 32'h1, 6'd15, 32'h1});
        v.push_back('{6'b000000, 32'h0000_FFFF, 32'h1, 6'd15, 32'h7FFF_8000});
        v.push_back('{6'b000011, 32'h8000_0000, 32'h24, 6'd4, 32'hF800_0000});
        v.push_back('{6'b000010, 32'h8000_0000, 32'h24, 6'd4, 32'h0800_0000});
        v.push_back('{6'b000111, 32'h8000_0000, 32'h24, 6'd4, 32'hF800_0000});
        v.push_back('{6'b000011, 32'h8000_0000, 32'h0, 6'd36, 32'hF800_0000});
        foreach (v[i]) begin
            drive(1'b1, v[i].op, v[i].a, v[i].b, v[i].sa);
            er = v[i].r;
            n_cmp++;
            if ({r, zero, negative, positive, out_valid, overflow} !==
                {er, er == 32'd0, er[31], (er != 32'd0) && !er[31], 1'b1, model_ovf(v[i].op, v[i].a, v[i].b)}) begin
                n_err++;
                $display("FAIL directed[%0d] op=%b: got r=%h znpvo=%b want r=%h znpvo=%b", i, v[i].op,
                         r, {zero, negative, positive, out_valid, overflow},
                         er, {er == 32'd0, er[31], (er != 32'd0) && !er[31], 1'b1, model_ovf(v[i].op, v[i].a, v[i].b)});
            end
        end
    endtask

    task automatic test_overflow;
        logic exp_o;
`ifdef ALU_OVERFLOW_EN
        exp_o = 1'b1;
`else
        exp_o = 1'b0;
`endif
        drive(1'b1, 6'b100000, 32'h7FFF_FFFF, 32'h1, 6'd0);
        n_cmp++;
        if ({r, negative, overflow} !== {32'h8000_0000, 1'b1, exp_o}) begin
            n_err++; $display("FAIL ovf_add: got r=%h n=%b o=%b want r=80000000 n=1 o=%b", r, negative, overflow, exp_o);
        end
        drive(1'b1, 6'b100010, 32'h8000_0000, 32'h1, 6'd0);
        n_cmp++;
        if ({r, overflow} !== {32'h7FFF_FFFF, exp_o}) begin
            n_err++; $display("FAIL ovf_sub: got r=%h o=%b want r=7fffffff o=%b", r, overflow, exp_o);
        end
        drive(1'b1, 6'b100100, 32'h7FFF_FFFF, 32'h1, 6'd0);
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_and: got %b want 0", overflow); end
    endtask

    task automatic test_hold_and_undef;
        drive(1'b1, 6'b100010, 32'h5, 32'h9, 6'd0);
        repeat (2) begin
            drive(1'b0, 6'b100000, $urandom, $urandom, 6'($urandom));
            n_cmp++;
            if ({r, zero, negative, positive, out_valid} !== {32'hFFFF_FFFC, 4'b0100}) begin
                n_err++; $display("FAIL hold: got r=%h znpv=%b want r=fffffffc znpv=0100",
                                  r, {zero, negative, positive, out_valid});
            end
        end
        drive(1'b1, 6'b111111, 32'hDEAD_BEEF, 32'h1234_5678, 6'd7);
        n_cmp++;
        if ({r, zero, negative, positive, out_valid} !== {32'd0, 4'b1001}) begin
            n_err++; $display("FAIL undef_op: got r=%h znpv=%b want r=0 znpv=1001",
                              r, {zero, negative, positive, out_valid});
        end
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 6'b100101, 32'hF0F0_0000, 32'h0000_0F0F, 6'd0);
        rst_n = 1'b0;
        drive(1'b1, 6'b100000, 32'h1, 32'h1, 6'd0);
        n_cmp++;
        if ({r, zero, negative, positive, out_valid, overflow} !== {32'd0, 5'b00000}) begin
            n_err++; $display("FAIL midstream_reset: got r=%h znpvo=%b want r=0 00000",
                              r, {zero, negative, positive, out_valid, overflow});
        end
        rst_n = 1'b1;
        drive(1'b0, 6'b100000, 32'h1, 32'h1, 6'd0);
        n_cmp++;
        if ({r, out_valid} !== {32'd0, 1'b0}) begin
            n_err++; $display("FAIL midstream_after: got r=%h v=%b want r=0 v=0", r, out_valid);
        end
    endtask

    task automatic test_random;
        logic [5:0]  ops [14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010,
                                  6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                                  6'b111111, 6'b001000};
        logic [31:0] er;
        logic        ez, en, ep, eo, v;
        logic [5:0]  o, xs;
        logic [31:0] xa, xb;
        er = 32'd0; ez = 1'b0; en = 1'b0; ep = 1'b0; eo = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            o  = ops[$urandom_range(0, 13)];
            xa = $urandom;
            xb = $urandom;
            if ($urandom_range(0, 3) == 0) xb = xa;
            if ($urandom_range(0, 5) == 0) xa = {1'b0, {31{1'b1}}};
            xs = 6'($urandom);
            drive(v, o, xa, xb, xs);
            if (v) begin
                er = model_r(o, xa, xb, xs);
                ez = (er == 32'd0);
                en = (sval(er) < 0);
                ep = (sval(er) > 0);
                eo = model_ovf(o, xa, xb);
            end
            n_cmp++;
            if ({r, zero, negative, positive, out_valid, overflow} !== {er, ez, en, ep, v, eo}) begin
                n_err++;
                $display("FAIL random[%0d] op=%b a=%h b=%h sa=%0d: got r=%h znpvo=%b want r=%h znpvo=%b",
                         i, o, xa, xb, xs, r, {zero, negative, positive, out_valid, overflow},
                         er, {ez, en, ep, v, eo});
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        op = 6'd0;
        a = 32'd0;
        b = 32'd0;
        sa = 6'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_overflow();
        test_hold_and_undef();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
